// File: rtl/topk_dispatch_pkg.sv
// Shared widths, FSM encoding and the sorted-entry record for the top-k receive path.
package topk_dispatch_pkg;

    localparam int K       = 8;
    localparam int SCORE_W = 16;
    localparam int ID_W    = 7;
    localparam int RANK_W  = 3;
    localparam int CNT_W   = $clog2(K + 1);
    localparam int SLOT_W  = $clog2(K);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPATCH = 2'd2
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [SCORE_W-1:0] score;
    } entry_t;

endpackage

// File: rtl/topk_dispatch_if.sv
// Selector-beat and dispatch handshake bundle; slave is the dispatcher's view.
interface topk_dispatch_if;
    import topk_dispatch_pkg::*;

    logic                topk_valid;
    logic [SCORE_W-1:0]  topk_score;
    logic [K*ID_W-1:0]   topk_id;
    logic                disp_valid;
    logic                disp_ready;
    logic [ID_W-1:0]     disp_id;
    logic [SCORE_W-1:0]  disp_score;
    logic [RANK_W-1:0]   disp_rank;
    logic                disp_done;

    modport master (
        output topk_valid, topk_score, topk_id, disp_ready,
        input  disp_valid, disp_id, disp_score, disp_rank, disp_done
    );

    modport slave (
        input  topk_valid, topk_score, topk_id, disp_ready,
        output disp_valid, disp_id, disp_score, disp_rank, disp_done
    );

endinterface

// File: rtl/topk_sort_insert.sv
// One-step insertion into a descending sorted array; existing entries with an equal
// score stay ahead of the new one, which keeps earlier slots at lower rank.
module topk_sort_insert
    import topk_dispatch_pkg::*;
(
    input  entry_t [K-1:0]   cur_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  entry_t           new_i,
    output entry_t [K-1:0]   nxt_o
);

    logic [K-1:0] keep;

    // keep[] is a true-prefix over the filled region, so the insert point is
    // simply the first position whose predecessor was kept.
    for (genvar i = 0; i < K; i++) begin : g_ent
        assign keep[i] = (CNT_W'(i) < cnt_i) && (cur_i[i].score >= new_i.score);
        if (i == 0) begin : g_head
            assign nxt_o[i] = keep[i] ? cur_i[i] : new_i;
        end else begin : g_body
            assign nxt_o[i] = keep[i]   ? cur_i[i] :
                              keep[i-1] ? new_i    : cur_i[i-1];
        end
    end

endmodule

// File: rtl/topk_dispatch.sv
// Collects K score beats plus the id bus, sorts them on arrival, then dispatches
// the experts highest-score first over a valid/ready port.
module topk_dispatch
    import topk_dispatch_pkg::*;
#(
    parameter bit DROP_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    topk_dispatch_if.slave   bus,
    output logic             busy,
    output logic             err_overrun,
    input  logic             err_clr
);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [RANK_W-1:0]        rank_q, rank_d;
    entry_t [K-1:0]           sorted_q, sorted_d;
    entry_t [K-1:0]           ins_nxt;
    logic [K-1:0][ID_W-1:0]   ids_q, ids_d;
    logic [K-1:0][ID_W-1:0]   ids_in;
    entry_t                   ins_new;
    entry_t                   out_q, out_d;
    entry_t                   nxt_ent;
    logic [RANK_W-1:0]        nxt_rank;
    logic                     last_ent;
    logic                     vld_q, vld_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    assign ids_in = bus.topk_id;

    // Beat 0 takes its id straight off the bus; later beats use the captured copy.
    always_comb begin
        ins_new.score = bus.topk_score;
        ins_new.id    = (state_q == S_IDLE) ? ids_in[0] : ids_q[cnt_q[SLOT_W-1:0]];
    end

    topk_sort_insert u_sort (
        .cur_i (sorted_q),
        .cnt_i (cnt_q),
        .new_i (ins_new),
        .nxt_o (ins_nxt)
    );

    assign nxt_rank = rank_q + RANK_W'(1);
    assign nxt_ent  = sorted_q[nxt_rank];
    assign last_ent = (rank_q == RANK_W'(K - 1)) || (DROP_ZERO && (nxt_ent.score == '0));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rank_d   = rank_q;
        sorted_d = sorted_q;
        ids_d    = ids_q;
        out_d    = out_q;
        vld_d    = vld_q;
        done_d   = 1'b0;
        err_d    = err_q;

        if (err_clr)
            err_d = 1'b0;
        else if (state_q == S_DISPATCH && bus.topk_valid)
            err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.topk_valid) begin
                    ids_d    = ids_in;
                    sorted_d = ins_nxt;
                    cnt_d    = CNT_W'(1);
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.topk_valid) begin
                    sorted_d = ins_nxt;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(K - 1)) begin
                        // Preload rank 0 from the fresh array so it is visible next cycle.
                        state_d = S_DISPATCH;
                        cnt_d   = '0;
                        rank_d  = '0;
                        out_d   = ins_nxt[0];
                        vld_d   = !(DROP_ZERO && (ins_nxt[0].score == '0));
                    end
                end
            end
            S_DISPATCH: begin
                if (!vld_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.disp_ready) begin
                    if (last_ent) begin
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rank_d = nxt_rank;
                        out_d  = nxt_ent;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rank_q   <= '0;
            sorted_q <= '0;
            ids_q    <= '0;
            out_q    <= '0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rank_q   <= rank_d;
            sorted_q <= sorted_d;
            ids_q    <= ids_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.disp_valid = vld_q;
    assign bus.disp_id    = out_q.id;
    assign bus.disp_score = out_q.score;
    assign bus.disp_rank  = rank_q;
    assign bus.disp_done  = done_q;
    assign busy           = (state_q != S_IDLE);
    assign err_overrun    = err_q;

endmodule

// File: tb/tb_topk_dispatch.sv
// Scenario bench for topk_dispatch: spec vectors plus random sets against a selection-sort model.
module tb_topk_dispatch;
    import topk_dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic busy, err_overrun;

    topk_dispatch_if bus();

    topk_dispatch #(.DROP_ZERO(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .err_overrun (err_overrun),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int sc[K];
    int idv[K];
    int exp_id[$], exp_sc[$];
    int obs_id[$], obs_sc[$], obs_rk[$], acc_it[$];
    int done_cnt, done_it, stall_viol, first_vld_it, vld_after_done;
    int err_hist[64];

    // Reference: repeatedly pick the highest remaining score, lowest slot on ties; stop at zero.
    task automatic build_expected();
        bit used[K];
        int b;
        exp_id.delete();
        exp_sc.delete();
        for (int i = 0; i < K; i++) used[i] = 1'b0;
        for (int n = 0; n < K; n++) begin
            b = -1;
            for (int i = 0; i < K; i++)
                if (!used[i] && (b < 0 || sc[i] > sc[b])) b = i;
            if (sc[b] == 0) break;
            used[b] = 1'b1;
            exp_id.push_back(idv[b]);
            exp_sc.push_back(sc[b]);
        end
    endtask

    task automatic rand_set(input bit allow_zero);
        for (int s = 0; s < K; s++) begin
            idv[s] = $urandom_range(0, 127);
            sc[s]  = (allow_zero && $urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
        end
    endtask

    task automatic send_set(input bit gaps, input int nbeats);
        logic [K*ID_W-1:0] idbus;
        for (int s = 0; s < K; s++) idbus[s*ID_W +: ID_W] = ID_W'(idv[s]);
        for (int s = 0; s < nbeats; s++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    bus.topk_valid = 1'b0;
                    bus.topk_score = SCORE_W'($urandom);
                end
            @(negedge clk);
            bus.topk_valid = 1'b1;
            bus.topk_score = SCORE_W'(sc[s]);
            bus.topk_id    = idbus;
        end
        @(negedge clk);
        bus.topk_valid = 1'b0;
        bus.topk_score = '0;
    endtask

    // Drives ready per mode (0 always, 1 pattern 1-0-0-1, 2 random) and records what is accepted.
    task automatic run_dispatch(input int mode, input logic [31:0] ov_mask, input logic [31:0] clr_mask);
        int it, since;
        logic pv, pr;
        logic [ID_W-1:0] pid;
        logic [SCORE_W-1:0] ps;
        logic [RANK_W-1:0] prk;
        obs_id.delete(); obs_sc.delete(); obs_rk.delete(); acc_it.delete();
        done_cnt = 0; done_it = -1; stall_viol = 0; first_vld_it = -1; vld_after_done = 0;
        it = 0; since = -1; pv = 1'b0; pr = 1'b0; pid = '0; ps = '0; prk = '0;
        while (it < 80 && since < 3) begin
            if (it < 64) err_hist[it] = int'(err_overrun);
            if (bus.disp_done) begin
                done_cnt++;
                if (done_it < 0) done_it = it;
                if (since < 0) since = 0;
            end
            if (since > 0 && bus.disp_valid) vld_after_done++;
            if (bus.disp_valid && first_vld_it < 0) first_vld_it = it;
            if (pv && !pr && !(bus.disp_valid && bus.disp_id == pid &&
                               bus.disp_score == ps && bus.disp_rank == prk))
                stall_viol++;
            case (mode)
                0:       bus.disp_ready = 1'b1;
                1:       bus.disp_ready = (it % 4 == 0) || (it % 4 == 3);
                default: bus.disp_ready = 1'($urandom_range(0, 1));
            endcase
            bus.topk_valid = (it < 32) ? ov_mask[it] : 1'b0;
            bus.topk_score = SCORE_W'($urandom);
            err_clr        = (it < 32) ? clr_mask[it] : 1'b0;
            if (bus.disp_valid && bus.disp_ready) begin
                obs_id.push_back(int'(bus.disp_id));
                obs_sc.push_back(int'(bus.disp_score));
                obs_rk.push_back(int'(bus.disp_rank));
                acc_it.push_back(it);
            end
            pv = bus.disp_valid; pr = bus.disp_ready;
            pid = bus.disp_id; ps = bus.disp_score; prk = bus.disp_rank;
            @(negedge clk);
            it++;
            if (since >= 0) since++;
        end
        bus.topk_valid = 1'b0;
        bus.disp_ready = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] v;
        bus.topk_valid = 1'b0; bus.topk_score = '0; bus.topk_id = '0; bus.disp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        v = 64'({bus.disp_valid, bus.disp_done, bus.disp_id, bus.disp_score, bus.disp_rank, busy, err_overrun});
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", v); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        v = 64'({bus.disp_valid, bus.disp_done, busy, err_overrun});
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL post_reset_idle got %h exp 0", v); end
    endtask

    task automatic test_basic();
        int eid[8] = '{7, 3, 5, 1, 6, 2, 4, 0};
        int esc[8] = '{80, 70, 60, 50, 40, 30, 20, 10};
        int bsc[8] = '{10, 50, 30, 70, 20, 60, 40, 80};
        for (int s = 0; s < K; s++) begin sc[s] = bsc[s]; idv[s] = s; end
        send_set(1'b0, K);
        run_dispatch(0, 32'd0, 32'd0);
        checks++;
        if (obs_id.size() != 8) begin errors++; $display("FAIL basic_count got %0d exp 8", obs_id.size()); end
        for (int i = 0; i < 8 && i < obs_id.size(); i++) begin
            checks++;
            if (obs_id[i] != eid[i] || obs_sc[i] != esc[i] || obs_rk[i] != i) begin
                errors++;
                $display("FAIL basic_entry%0d got id=%0d sc=%0d rk=%0d exp id=%0d sc=%0d rk=%0d",
                         i, obs_id[i], obs_sc[i], obs_rk[i], eid[i], esc[i], i);
            end
        end
        checks++;
        if (first_vld_it != 0) begin errors++; $display("FAIL basic_latency got %0d exp 0", first_vld_it); end
        checks++;
        if (acc_it.size() == 8 && acc_it[7] - acc_it[0] != 7) begin
            errors++; $display("FAIL basic_throughput got %0d exp 7", acc_it[7] - acc_it[0]);
        end
        checks++;
        if (done_cnt != 1 || done_it != 8) begin
            errors++; $display("FAIL basic_done got cnt=%0d at=%0d exp cnt=1 at=8", done_cnt, done_it);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", busy); end
    endtask

    task automatic test_ties();
        int eid[4] = '{2, 0, 1, 3};
        int esc[4] = '{9, 5, 5, 5};
        int tsc[8] = '{5, 5, 9, 5, 0, 0, 0, 0};
        for (int s = 0; s < K; s++) begin sc[s] = tsc[s]; idv[s] = s; end
        send_set(1'b0, K);
        run_dispatch(0, 32'd0, 32'd0);
        checks++;
        if (obs_id.size() != 4) begin errors++; $display("FAIL ties_count got %0d exp 4", obs_id.size()); end
        for (int i = 0; i < 4 && i < obs_id.size(); i++) begin
            checks++;
            if (obs_id[i] != eid[i] || obs_sc[i] != esc[i] || obs_rk[i] != i) begin
                errors++;
                $display("FAIL ties_entry%0d got id=%0d sc=%0d rk=%0d exp id=%0d sc=%0d rk=%0d",
                         i, obs_id[i], obs_sc[i], obs_rk[i], eid[i], esc[i], i);
            end
        end
        checks++;
        if (done_cnt != 1 || acc_it.size() == 0 || done_it != acc_it[acc_it.size()-1] + 1) begin
            errors++; $display("FAIL ties_done got cnt=%0d at=%0d exp cnt=1 at=4", done_cnt, done_it);
        end
    endtask

    task automatic test_all_zero();
        for (int s = 0; s < K; s++) begin sc[s] = 0; idv[s] = s + 10; end
        send_set(1'b0, K);
        run_dispatch(0, 32'd0, 32'd0);
        checks++;
        if (first_vld_it != -1) begin errors++; $display("FAIL zero_valid got first=%0d exp none", first_vld_it); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL zero_done got %0d exp 1", done_cnt); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", busy); end
    endtask

    task automatic test_stall();
        rand_set(1'b0);
        build_expected();
        send_set(1'b0, K);
        run_dispatch(1, 32'd0, 32'd0);
        checks++;
        if (obs_id.size() != exp_id.size()) begin
            errors++; $display("FAIL stall_count got %0d exp %0d", obs_id.size(), exp_id.size());
        end
        for (int i = 0; i < exp_id.size() && i < obs_id.size(); i++) begin
            checks++;
            if (obs_id[i] != exp_id[i] || obs_sc[i] != exp_sc[i] || obs_rk[i] != i) begin
                errors++;
                $display("FAIL stall_entry%0d got id=%0d sc=%0d exp id=%0d sc=%0d",
                         i, obs_id[i], obs_sc[i], exp_id[i], exp_sc[i]);
            end
        end
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL stall_hold got %0d changes exp 0", stall_viol); end
        checks++;
        if (done_cnt != 1 || vld_after_done != 0) begin
            errors++; $display("FAIL stall_done got cnt=%0d late_vld=%0d exp 1/0", done_cnt, vld_after_done);
        end
    endtask

    task automatic test_overrun();
        for (int s = 0; s < K; s++) begin sc[s] = $urandom_range(1, 1000); idv[s] = $urandom_range(0, 127); end
        build_expected();
        send_set(1'b0, K);
        run_dispatch(1, 32'h2A, 32'h08);
        checks++;
        if (obs_id.size() != exp_id.size()) begin
            errors++; $display("FAIL ovr_count got %0d exp %0d", obs_id.size(), exp_id.size());
        end
        for (int i = 0; i < exp_id.size() && i < obs_id.size(); i++) begin
            checks++;
            if (obs_id[i] != exp_id[i] || obs_sc[i] != exp_sc[i]) begin
                errors++;
                $display("FAIL ovr_entry%0d got id=%0d sc=%0d exp id=%0d sc=%0d",
                         i, obs_id[i], obs_sc[i], exp_id[i], exp_sc[i]);
            end
        end
        checks++;
        if (err_hist[2] != 1 || err_hist[4] != 0 || err_hist[6] != 1) begin
            errors++;
            $display("FAIL ovr_sticky got %0d%0d%0d exp 101", err_hist[2], err_hist[4], err_hist[6]);
        end
        checks++;
        if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_hold got %b exp 1", err_overrun); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", err_overrun); end
    endtask

    task automatic test_gaps_reset();
        logic [63:0] v;
        int bad;
        rand_set(1'b0);
        send_set(1'b1, 3);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        v = 64'({bus.disp_valid, bus.disp_done, bus.disp_id, bus.disp_score, bus.disp_rank, busy, err_overrun});
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL midreset_outputs got %h exp 0", v); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.disp_valid || bus.disp_done || busy) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midreset_quiet got %0d active cycles exp 0", bad); end
        rand_set(1'b1);
        build_expected();
        send_set(1'b1, K);
        run_dispatch(2, 32'd0, 32'd0);
        checks++;
        if (obs_id.size() != exp_id.size()) begin
            errors++; $display("FAIL gap_count got %0d exp %0d", obs_id.size(), exp_id.size());
        end
        for (int i = 0; i < exp_id.size() && i < obs_id.size(); i++) begin
            checks++;
            if (obs_id[i] != exp_id[i] || obs_sc[i] != exp_sc[i] || obs_rk[i] != i) begin
                errors++;
                $display("FAIL gap_entry%0d got id=%0d sc=%0d exp id=%0d sc=%0d",
                         i, obs_id[i], obs_sc[i], exp_id[i], exp_sc[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            rand_set(1'b1);
            build_expected();
            send_set(n[0], K);
            run_dispatch(2, 32'd0, 32'd0);
            checks++;
            if (obs_id.size() != exp_id.size() || done_cnt != 1) begin
                errors++;
                $display("FAIL rand%0d_count got %0d done=%0d exp %0d done=1",
                         n, obs_id.size(), done_cnt, exp_id.size());
            end
            for (int i = 0; i < exp_id.size() && i < obs_id.size(); i++) begin
                checks++;
                if (obs_id[i] != exp_id[i] || obs_sc[i] != exp_sc[i] || obs_rk[i] != i) begin
                    errors++;
                    $display("FAIL rand%0d_entry%0d got id=%0d sc=%0d rk=%0d exp id=%0d sc=%0d rk=%0d",
                             n, i, obs_id[i], obs_sc[i], obs_rk[i], exp_id[i], exp_sc[i], i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_all_zero();
        test_stall();
        test_overrun();
        test_gaps_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
